lane_serializer: RTL and testbench
==================================

# lane_serializer

Multi-lane, FIFO-buffered parallel-to-serial converter: the parametrised successor to the single-lane serializer in the gray-area link transmit path. Accepted words are queued, optionally extended with Hamming parity, and shifted out MSB-first over LANES parallel serial lines, with frame framing (start/enable), back-to-back frames and a configurable inter-frame gap. Drives the matching deserializer on the receive side.

## Interface
- DATA_WIDTH, 8: payload bits per word (≥2)
- LANES, 1: serial output lines (1..PAYLOAD_WIDTH)
- HAS_ECC, 0: 1 = append CODE_BITS Hamming parity bits after data
- FIFO_DEPTH, 2: input queue entries (≥1)
- GAP_CYCLES, 0: idle cycles forced between frames (0..15)
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- parallel_in_i  in  DATA_WIDTH  word to send
- valid_in_i  in  1  word present
- ready_o  out  1  queue can accept (push = valid_in_i && ready_o)
- serial_out_o  out  LANES  current beat bits
- enable_o  out  1  serial_out_o carries a frame beat
- start_o  out  1  first beat of a frame
- busy_o  out  1  frame in flight or queue non-empty

## Operation
- CODE_BITS = smallest p with 2^p ≥ DATA_WIDTH+p+1 (8→4); PAYLOAD_WIDTH = DATA_WIDTH + HAS_ECC·CODE_BITS; BEATS = ceil(PAYLOAD_WIDTH/LANES).
- Frame = {data, parity} (parity LSBs, omitted when HAS_ECC=0), zero-padded at LSB end to BEATS·LANES bits.
- Beat k, lane l carries frame bit PAYLOAD_WIDTH-1-(k·LANES+l); lane 0 = most significant bit of beat; pad bits drive 0.
- Parity computed combinationally at push, stored with word in queue (queue width PAYLOAD_WIDTH).
- States: IDLE (no frame), SHIFT (beat counter 0..BEATS-1), GAP (countdown GAP_CYCLES).
- IDLE → SHIFT: queue non-empty; head popped into shift register, beat 0 driven.
- SHIFT: beat BEATS-1 displayed → GAP if GAP_CYCLES>0, else pop next head (back-to-back) or IDLE if empty.
- GAP → SHIFT/IDLE when countdown reaches 0, same rule.
- ready_o = !full && !rst_i; based on stored count only (no same-cycle pop look-through).
- Outside enable_o: serial_out_o = 0, start_o = 0.

## Timing
- All outputs except ready_o registered.
- Reset values: serial_out_o 0, enable_o 0, start_o 0, busy_o 0, ready_o 0 while rst_i high; queue emptied, state IDLE.
- Latency: push at edge E0 into empty queue/IDLE → beat 0 (start_o=1, enable_o=1) visible after E1.
- Frame occupies exactly BEATS consecutive enable_o cycles; start_o high on first only.
- Back-to-back (GAP_CYCLES=0, queue non-empty): next start_o on cycle immediately after last beat; enable_o stays high.
- GAP_CYCLES=N: exactly N enable_o=0 cycles between frames.
- Simultaneous push and pop: both occur; count unchanged.
- Full: ready_o low; valid_in_i ignored, parallel_in_i need not be held by this block's contract beyond handshake.
- Reset mid-frame: outputs 0 after reset edge, frame and queued words discarded, ready_o high first cycle after rst_i drops.
- Beat counter width $clog2(BEATS)+1; no wrap beyond BEATS-1.

## Structure
- gray_area_package: function code_bits(dw), function hamming_parity(data) (same bit convention as hamming_encode), typedef ser_state_t {IDLE, SHIFT, GAP}.
- Sub-module: ser_fifo (synchronous FIFO, WIDTH, DEPTH; push/pop/full/empty/count), instantiated once.

## Test plan
- LANES=1, HAS_ECC=0, push 0xA5 → serial 1,0,1,0,0,1,0,1 over 8 enable cycles, start_o on first, latency 1 edge after push.
- LANES=2, push 0xA5 → beats {lane0,lane1} = (1,0),(1,0),(0,1),(0,1); 4 enable cycles.
- HAS_ECC=1, LANES=3, push 0xA5 → 4 beats carrying {0xA5, hamming_parity(0xA5)} (12 bits), no padding; LANES=5 → 3 beats, last 3 bits 0.
- FIFO_DEPTH=2, push 0x01,0x02,0x03 consecutive cycles → ready_o low one cycle after third push attempt when full; frames sent back-to-back, 24 continuous enable cycles, start_o at cycles 0,8,16 relative.
- GAP_CYCLES=3, two queued words → exactly 3 enable_o=0 cycles between frames.
- rst_i asserted at beat 4 of 0xA5 with 0x3C queued → all outputs 0 next cycle, 0x3C never transmitted, busy_o 0.

Source files
------------

// File: rtl/lane_serializer_pkg.sv
// Shared types and helpers for the multi-lane serializer: state encoding,
// Hamming code-width calculation and parity generation.
package lane_serializer_pkg;

  localparam int MAX_DW = 64;
  localparam int MAX_CB = 8;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} ser_state_t;

  // Smallest p with 2^p >= dw + p + 1.
  function automatic int code_bits(input int dw);
    int p;
    p = 1;
    while ((1 << p) < dw + p + 1) p++;
    return p;
  endfunction

  // Data bit i sits at the i-th non-power-of-two codeword position (1-based);
  // parity bit k is the XOR of all data bits whose position has bit k set.
  function automatic logic [MAX_CB-1:0] hamming_parity(input logic [MAX_DW-1:0] data,
                                                       input int dw);
    logic [MAX_CB-1:0] par;
    int di;
    par = '0;
    di  = 0;
    for (int pos = 1; pos < 2 * MAX_DW; pos++) begin
      if (di < dw && (pos & (pos - 1)) != 0) begin
        if (data[di[5:0]]) par = par ^ MAX_CB'(pos);
        di++;
      end
    end
    return par;
  endfunction

endpackage

// File: rtl/lane_serializer_fifo.sv
// Synchronous FIFO buffering encoded words ahead of the shifter.
module ser_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               din,
  output logic [WIDTH-1:0]               dout,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/lane_serializer.sv
// FIFO-buffered parallel-to-serial converter driving LANES serial lines
// MSB-first, with optional Hamming parity and a configurable inter-frame gap.
module lane_serializer import lane_serializer_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 1,
  parameter int HAS_ECC    = 0,
  parameter int FIFO_DEPTH = 2,
  parameter int GAP_CYCLES = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] parallel_in_i,
  input  logic                  valid_in_i,
  output logic                  ready_o,
  output logic [LANES-1:0]      serial_out_o,
  output logic                  enable_o,
  output logic                  start_o,
  output logic                  busy_o
);

  localparam int CB    = code_bits(DATA_WIDTH);
  localparam int PW    = DATA_WIDTH + ((HAS_ECC != 0) ? CB : 0);
  localparam int BEATS = (PW + LANES - 1) / LANES;
  localparam int FW    = BEATS * LANES;
  localparam int BW    = $clog2(BEATS) + 1;
  localparam int QCW   = $clog2(FIFO_DEPTH + 1);

  logic [PW-1:0]    q_din, q_dout;
  logic             full, empty, push, pop;
  logic [QCW-1:0]   count, count_next;
  ser_state_t       state;
  logic [BW-1:0]    beat;
  logic [3:0]       gap_cnt;
  logic [FW-1:0]    sr, frame;
  logic [LANES-1:0] frame_beat, sr_beat;
  logic             last_beat, in_flight_next;

  assign ready_o = !full && !rst_i;
  assign push    = valid_in_i && ready_o;

  generate
    if (HAS_ECC != 0) begin : g_ecc
      logic [MAX_CB-1:0] par;
      assign par   = hamming_parity(MAX_DW'(parallel_in_i), DATA_WIDTH);
      assign q_din = {parallel_in_i, par[CB-1:0]};
    end else begin : g_raw
      assign q_din = parallel_in_i;
    end
  endgenerate

  ser_fifo #(.WIDTH(PW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .pop   (pop),
    .din   (q_din),
    .dout  (q_dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Frame left-aligned so padding lands at the LSB end.
  assign frame = FW'(q_dout) << (FW - PW);

  // Lane 0 carries the most significant bit of each beat.
  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign frame_beat[l] = frame[FW-1-l];
      assign sr_beat[l]    = sr[FW-1-l];
    end
  endgenerate

  assign last_beat = (state == SHIFT) && (beat == BW'(BEATS - 1));
  assign pop = !empty && ((state == IDLE) ||
                          (last_beat && GAP_CYCLES == 0) ||
                          (state == GAP && gap_cnt == '0));
  assign in_flight_next = pop || ((state == SHIFT) && !last_beat) ||
                          (last_beat && GAP_CYCLES > 0) ||
                          ((state == GAP) && gap_cnt != '0);
  assign count_next = count + QCW'(push) - QCW'(pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      beat         <= '0;
      gap_cnt      <= '0;
      sr           <= '0;
      serial_out_o <= '0;
      enable_o     <= 1'b0;
      start_o      <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      busy_o  <= in_flight_next || (count_next != '0);
      start_o <= 1'b0;
      if (pop) begin
        state        <= SHIFT;
        beat         <= '0;
        serial_out_o <= frame_beat;
        sr           <= frame << LANES;
        enable_o     <= 1'b1;
        start_o      <= 1'b1;
      end else begin
        case (state)
          SHIFT: begin
            if (!last_beat) begin
              beat         <= beat + 1'b1;
              serial_out_o <= sr_beat;
              sr           <= sr << LANES;
            end else begin
              enable_o     <= 1'b0;
              serial_out_o <= '0;
              state        <= (GAP_CYCLES > 0) ? GAP : IDLE;
              gap_cnt      <= 4'(GAP_CYCLES - 1);
            end
          end
          GAP: begin
            if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
            else               state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lane_serializer.sv
// Four serializer configurations driven by one shared input stream, each
// checked every cycle against a frame-schedule model of the link.
module tb_lane_serializer;

  typedef struct {
    int         inst;
    int         push;
    int         start;
    logic [7:0] d;
  } rec_t;

  localparam int CL [4] = '{1, 2, 3, 5};
  localparam int CE [4] = '{0, 0, 1, 1};
  localparam int CD [4] = '{2, 2, 4, 1};
  localparam int CG [4] = '{0, 1, 3, 0};

  logic       clk = 1'b0;
  logic       rst;
  logic       vin;
  logic [7:0] din;
  logic       lit_on;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  logic [3:0] rdy, en, st, bz;
  logic [0:0] so0;
  logic [1:0] so1;
  logic [2:0] so2;
  logic [4:0] so3;
  logic [4:0] ser [4];

  rec_t        recs[$];
  int          nf [4];
  int          fcnt [4];
  logic [31:0] cap [4];
  logic        rdy_exp [4];
  logic [31:0] lit_exp [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lane_serializer #(.DATA_WIDTH(8), .LANES(1), .HAS_ECC(0), .FIFO_DEPTH(2), .GAP_CYCLES(0)) u0 (
    .clk_i(clk), .rst_i(rst), .parallel_in_i(din), .valid_in_i(vin), .ready_o(rdy[0]),
    .serial_out_o(so0), .enable_o(en[0]), .start_o(st[0]), .busy_o(bz[0]));
  lane_serializer #(.DATA_WIDTH(8), .LANES(2), .HAS_ECC(0), .FIFO_DEPTH(2), .GAP_CYCLES(1)) u1 (
    .clk_i(clk), .rst_i(rst), .parallel_in_i(din), .valid_in_i(vin), .ready_o(rdy[1]),
    .serial_out_o(so1), .enable_o(en[1]), .start_o(st[1]), .busy_o(bz[1]));
  lane_serializer #(.DATA_WIDTH(8), .LANES(3), .HAS_ECC(1), .FIFO_DEPTH(4), .GAP_CYCLES(3)) u2 (
    .clk_i(clk), .rst_i(rst), .parallel_in_i(din), .valid_in_i(vin), .ready_o(rdy[2]),
    .serial_out_o(so2), .enable_o(en[2]), .start_o(st[2]), .busy_o(bz[2]));
  lane_serializer #(.DATA_WIDTH(8), .LANES(5), .HAS_ECC(1), .FIFO_DEPTH(1), .GAP_CYCLES(0)) u3 (
    .clk_i(clk), .rst_i(rst), .parallel_in_i(din), .valid_in_i(vin), .ready_o(rdy[3]),
    .serial_out_o(so3), .enable_o(en[3]), .start_o(st[3]), .busy_o(bz[3]));

  assign ser[0] = {4'b0, so0};
  assign ser[1] = {3'b0, so1};
  assign ser[2] = {2'b0, so2};
  assign ser[3] = so3;

  // Hamming parity via an explicit 12-position codeword.
  function automatic logic [3:0] tb_par(input logic [7:0] d);
    logic [12:0] cw;
    logic [3:0]  p;
    int k;
    cw = '0;
    k  = 0;
    for (int pos = 1; pos <= 12; pos++)
      if (pos != 1 && pos != 2 && pos != 4 && pos != 8) begin
        cw[pos] = d[k];
        k++;
      end
    p = '0;
    for (int i = 0; i < 4; i++)
      for (int pos = 1; pos <= 12; pos++)
        if (((pos >> i) & 1) == 1) p[i] = p[i] ^ cw[pos];
    return p;
  endfunction

  // Bit j (0 = first on the wire) of the padded frame.
  function automatic logic frame_bit(input logic [7:0] d, input int ecc, input int j);
    logic [11:0] fr;
    int pw;
    pw = (ecc != 0) ? 12 : 8;
    fr = (ecc != 0) ? {d, tb_par(d)} : {4'b0, d};
    return (j < pw) ? fr[pw-1-j] : 1'b0;
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cyc %0d: got %0h expected %0h", nm, i, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin : cmp
    int pw, b, cnt, k, p, s;
    logic e_en, e_st, e_bz;
    logic [4:0] e_ser;
    rec_t nr;
    for (int i = 0; i < 4; i++) begin
      pw = 8 + 4 * CE[i];
      b  = (pw + CL[i] - 1) / CL[i];
      e_en = 1'b0; e_st = 1'b0; e_bz = 1'b0; e_ser = '0; cnt = 0;
      foreach (recs[r]) begin
        if (recs[r].inst == i) begin
          if (recs[r].push <= cyc && cyc < recs[r].start + b + CG[i]) e_bz = 1'b1;
          if (recs[r].push <= cyc && recs[r].start > cyc) cnt++;
          if (recs[r].start <= cyc && cyc < recs[r].start + b) begin
            e_en = 1'b1;
            e_st = (recs[r].start == cyc);
            k = cyc - recs[r].start;
            for (int l = 0; l < CL[i]; l++) e_ser[l] = frame_bit(recs[r].d, CE[i], k * CL[i] + l);
          end
        end
      end
      rdy_exp[i] = !rst && (cnt < CD[i]);
      chk("ready",  i, 32'(rdy[i]), 32'(rdy_exp[i]));
      chk("enable", i, 32'(en[i]),  32'(e_en));
      chk("start",  i, 32'(st[i]),  32'(e_st));
      chk("busy",   i, 32'(bz[i]),  32'(e_bz));
      chk("serial", i, 32'(ser[i]), 32'(e_ser));

      // Whole-frame capture compared against hand-computed wire images.
      if (st[i]) begin
        fcnt[i] = 1;
        cap[i]  = '0;
      end else if (en[i]) fcnt[i]++;
      if (en[i]) for (int l = 0; l < CL[i]; l++) cap[i] = {cap[i][30:0], ser[i][l]};
      if (en[i] && lit_on && fcnt[i] == b) chk("lit_frame", i, cap[i], lit_exp[i]);
    end

    if (cyc == 2) chk("parity_model", 0, 32'(tb_par(8'hA5)), 32'h3);

    if (rst) begin
      recs.delete();
      for (int i = 0; i < 4; i++) nf[i] = 0;
    end else if (vin) begin
      for (int i = 0; i < 4; i++) begin
        if (rdy_exp[i]) begin
          pw = 8 + 4 * CE[i];
          b  = (pw + CL[i] - 1) / CL[i];
          p  = cyc + 1;
          s  = (p + 1 > nf[i]) ? p + 1 : nf[i];
          nf[i] = s + b + CG[i];
          nr.inst = i; nr.push = p; nr.start = s; nr.d = din;
          recs.push_back(nr);
        end
      end
    end
    for (int r = recs.size() - 1; r >= 0; r--)
      if (recs[r].start + 40 < cyc) recs.delete(r);
  end

  task automatic drv(input logic v, input logic [7:0] d);
    @(posedge clk);
    #1;
    vin = v;
    din = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drv(1'b0, 8'($urandom));
  endtask

  initial begin
    lit_exp = '{32'hA5, 32'hA5, 32'hA53, 32'h5298};
    for (int i = 0; i < 4; i++) begin
      fcnt[i] = 0; cap[i] = '0; nf[i] = 0; rdy_exp[i] = 1'b0;
    end
    rst = 1'b1; vin = 1'b0; din = '0; lit_on = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    lit_on = 1'b1;
    drv(1'b1, 8'hA5);
    idle(30);
    lit_on = 1'b0;

    drv(1'b1, 8'h01); drv(1'b1, 8'h02); drv(1'b1, 8'h03);
    idle(45);

    // Reset while beat 4 of 0xA5 is on the wire, 0x3C still queued.
    drv(1'b1, 8'hA5); drv(1'b1, 8'h3C); drv(1'b0, 8'h00);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    idle(30);

    repeat (3000) begin
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 299) == 0);
      vin = ($urandom_range(0, 2) != 0);
      din = 8'($urandom);
    end
    #0 rst = 1'b0;
    idle(50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
